// File: rtl/fetch.sv
// Instruction fetch stage: owns the PC, single-outstanding imem requests,
// skid on stall, redirect flush. Optional MISALIGN_CHK_EN adds misalign_out.
module fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_data,
    output logic [31:0] IR_out,
    output logic [31:0] PC_out,
    output logic        valid_out
`ifdef MISALIGN_CHK_EN
    ,
    output logic        misalign_out
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_HOLD,
        S_DISCARD
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_req;
    logic [31:0] r_addr;
    logic [31:0] r_ir;
    logic [31:0] r_pc_out;
    logic        r_valid;
    logic [31:0] r_skid_ir;
    logic [31:0] r_skid_pc;

    logic [31:0] w_pc_next;
    logic [31:0] w_tgt;
    logic        w_consume;

    assign w_pc_next = r_pc + 32'd4;
    assign w_tgt     = redirect_pc & ~32'h3;
    // read stage takes the current output at this edge
    assign w_consume = r_valid && !stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_pc      <= RESET_PC;
            r_req     <= 1'b0;
            r_addr    <= RESET_PC;
            r_ir      <= NOP_INSTR;
            r_pc_out  <= 32'd0;
            r_valid   <= 1'b0;
            r_skid_ir <= NOP_INSTR;
            r_skid_pc <= 32'd0;
        end else if (redirect) begin
            r_pc      <= w_tgt;
            r_addr    <= w_tgt;
            r_req     <= 1'b0;
            r_valid   <= 1'b0;
            r_ir      <= NOP_INSTR;
            r_skid_ir <= NOP_INSTR;
            r_skid_pc <= 32'd0;
            // an unanswered request still owes one response
            unique case (r_state)
                S_WAIT:    r_state <= imem_valid ? S_IDLE : S_DISCARD;
                S_DISCARD: r_state <= S_DISCARD;
                S_IDLE:    r_state <= S_IDLE;
                S_HOLD:    r_state <= S_IDLE;
            endcase
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_req   <= 1'b1;
                    r_addr  <= r_pc;
                    r_state <= S_WAIT;
                    if (w_consume) begin
                        r_valid <= 1'b0;
                        r_ir    <= NOP_INSTR;
                    end
                end
                S_WAIT: begin
                    if (imem_valid) begin
                        r_pc <= w_pc_next;
                        if (!r_valid || !stall) begin
                            r_ir     <= imem_data;
                            r_pc_out <= r_pc;
                            r_valid  <= 1'b1;
                            r_addr   <= w_pc_next;
                        end else begin
                            r_skid_ir <= imem_data;
                            r_skid_pc <= r_pc;
                            r_req     <= 1'b0;
                            r_state   <= S_HOLD;
                        end
                    end else if (w_consume) begin
                        r_valid <= 1'b0;
                        r_ir    <= NOP_INSTR;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        r_ir     <= r_skid_ir;
                        r_pc_out <= r_skid_pc;
                        r_valid  <= 1'b1;
                        r_state  <= S_IDLE;
                    end
                end
                S_DISCARD: begin
                    r_req <= 1'b0;
                    if (imem_valid) begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

`ifdef MISALIGN_CHK_EN
    logic r_misalign;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= redirect && (redirect_pc[1:0] != 2'b00);
        end
    end

    assign misalign_out = r_misalign;
`endif

    assign imem_req  = r_req;
    assign imem_addr = r_addr;
    assign IR_out    = r_ir;
    assign PC_out    = r_pc_out;
    assign valid_out = r_valid;

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: memory model with variable latency, scoreboard of
// expected (PC, IR) pairs, table of redirect/stream runs, directed corners.
module tb_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_data;
    logic [31:0] IR_out;
    logic [31:0] PC_out;
    logic        valid_out;
`ifdef MISALIGN_CHK_EN
    logic        misalign_out;
`endif

    fetch #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (NOP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_valid  (imem_valid),
        .imem_data   (imem_data),
        .IR_out      (IR_out),
        .PC_out      (PC_out),
        .valid_out   (valid_out)
`ifdef MISALIGN_CHK_EN
        ,
        .misalign_out(misalign_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return 32'hC0DE_0000 ^ {a[15:0], a[31:16]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // memory model: accepts a request seen high during a cycle,
    // answers mem_lat cycles later, one outstanding at a time
    int          mem_lat = 1;
    bit          m_out;
    int          m_cnt;
    logic [31:0] m_addr;
    logic        s_req;
    logic [31:0] s_addr;

    initial begin
        s_req  = 1'b0;
        s_addr = '0;
        forever begin
            @(negedge clk);
            s_req  = imem_req;
            s_addr = imem_addr;
        end
    end

    initial begin
        imem_valid = 1'b0;
        imem_data  = '0;
        m_out      = 1'b0;
        m_cnt      = 0;
        m_addr     = '0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                m_out      = 1'b0;
                imem_valid = 1'b0;
            end else if (imem_valid) begin
                imem_valid = 1'b0;
                imem_data  = '0;
                m_out      = 1'b0;
            end else if (m_out) begin
                m_cnt--;
                if (m_cnt <= 0) begin
                    imem_valid = 1'b1;
                    imem_data  = instr_of(m_addr);
                end
            end else if (s_req) begin
                m_out  = 1'b1;
                m_addr = s_addr;
                m_cnt  = mem_lat - 1;
                if (m_cnt <= 0) begin
                    imem_valid = 1'b1;
                    imem_data  = instr_of(m_addr);
                end
            end
        end
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ir;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic [31:0] tgt;
        int          lat;
        int          pct;
        int          n;
        logic [31:0] first;
    } vec_t;

    task automatic do_redirect(input logic [31:0] tgt);
        sb.delete();
        redirect_pc = tgt;
        redirect    = 1'b1;
        @(posedge clk);
        #1;
        redirect = 1'b0;
    endtask

    // push expected stream, then pop on every consumed output
    task automatic run_stream(input int n, input int pct,
                              input logic [31:0] first);
        int   cyc;
        exp_t e;
        logic [31:0] a;
        a = first;
        for (int k = 0; k < n; k++) begin
            e.pc = a;
            e.ir = instr_of(a);
            sb.push_back(e);
            a = a + 32'd4;
        end
        cyc = 0;
        while (sb.size() > 0 && cyc < 40 * n + 40) begin
            @(negedge clk);
            cyc++;
            if (valid_out && !stall) begin
                e = sb.pop_front();
                chk("sb_pc", PC_out, e.pc);
                chk("sb_ir", IR_out, e.ir);
            end
            @(posedge clk);
            #2;
            stall = ($urandom_range(0, 99) < pct);
        end
        if (sb.size() > 0) begin
            chk("sb_timeout_left", sb.size(), 0);
            sb.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tab[5];
        int   cyc;

        tab[0] = '{32'h0000_1000, 1, 0,  6,  32'h0000_1000};
        tab[1] = '{32'hFFFF_FFFC, 1, 0,  3,  32'hFFFF_FFFC};
        tab[2] = '{32'h0000_2002, 2, 30, 8,  32'h0000_2000};
        tab[3] = '{32'h0000_3000, 3, 60, 8,  32'h0000_3000};
        tab[4] = '{32'h0000_4001, 1, 50, 10, 32'h0000_4000};

        reset       = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_ir", IR_out, NOP);
        chk("rst_pc", PC_out, 32'h0);
        chk("rst_valid", valid_out, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("first_req", imem_req, 1);
        chk("first_addr", imem_addr, 32'h0);
        run_stream(3, 0, 32'h0);

        // stall while a response lands: skid and HOLD
        stall = 1'b1;
        do_redirect(32'h200);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(valid_out && !imem_req) && cyc < 20);
        chk("hold_reached", cyc < 20, 1);
        chk("hold_pc", PC_out, 32'h200);
        chk("hold_ir", IR_out, instr_of(32'h200));
        repeat (3) @(negedge clk);
        chk("hold_frz_pc", PC_out, 32'h200);
        chk("hold_frz_v", valid_out, 1);
        chk("hold_frz_req", imem_req, 0);
        stall = 1'b0;
        @(negedge clk);
        chk("skid_valid", valid_out, 1);
        chk("skid_pc", PC_out, 32'h204);
        chk("skid_ir", IR_out, instr_of(32'h204));
        @(negedge clk);
        chk("after_skid_req", imem_req, 1);
        chk("after_skid_addr", imem_addr, 32'h208);
        chk("after_skid_valid", valid_out, 0);

        // redirect with the 0x208 response still owed, 3 cycles away
        mem_lat = 3;
        do_redirect(32'h100);
        mem_lat = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("disc_req", imem_req, 0);
            chk("disc_valid", valid_out, 0);
        end
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!imem_req && cyc < 10);
        chk("disc_addr", imem_addr, 32'h100);
        chk("disc_valid2", valid_out, 0);
        cyc = 0;
        while (!valid_out && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        chk("disc_new_pc", PC_out, 32'h100);
        chk("disc_new_ir", IR_out, instr_of(32'h100));

        // redirect in the same cycle as a response, while stalled
        stall = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!imem_valid && cyc < 10);
        chk("same_frz_pc", PC_out, 32'h100);
        chk("same_frz_v", valid_out, 1);
        do_redirect(32'h400);
        @(negedge clk);
        chk("same_valid", valid_out, 0);
        chk("same_ir", IR_out, NOP);
        chk("same_addr", imem_addr, 32'h400);
        chk("same_req", imem_req, 0);
        stall = 1'b0;
        cyc = 0;
        while (!valid_out && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        chk("same_new_pc", PC_out, 32'h400);
        chk("same_new_ir", IR_out, instr_of(32'h400));

`ifdef MISALIGN_CHK_EN
        do_redirect(32'h102);
        @(negedge clk);
        chk("mis_flag", misalign_out, 1);
        chk("mis_addr", imem_addr, 32'h100);
        @(negedge clk);
        chk("mis_flag_clr", misalign_out, 0);
        cyc = 0;
        while (!valid_out && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        chk("mis_pc", PC_out, 32'h100);
`endif

        for (int i = 0; i < 5; i++) begin
            mem_lat = tab[i].lat;
            do_redirect(tab[i].tgt);
            run_stream(tab[i].n, tab[i].pct, tab[i].first);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
